// File: rtl/lstm_job_ctrl.sv
// lstm_job_ctrl
// Sequencing controller in front of the 64-neuron LSTM.
//   job_*      : valid/ready job handshake carrying the Xin address range
//   bias_*     : valid/ready bias stream, forwarded one cycle later on
//                lstm_wren_a / lstm_wdata_b
//   lstm_start / lstm_*_addr : one-cycle start pulse plus the latched range
//   ht_valid / cycle_complete / lstm_done : run progress from the LSTM
//   lstm_reset : two-cycle datapath clear after each executed job
//   busy, job_done, err_*, ht_total : status, err_* and ht_total hold
//                until the next job is accepted
// Outputs other than the handshake readies are registered. They are
// computed from the next state, so each output lines up with the state
// it belongs to (job_done is high exactly while the FSM sits in REPORT).
module lstm_job_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 7,
    parameter int NUM_BIAS     = 256,
    parameter int HT_PER_CYCLE = 64,
    parameter int TIMEOUT      = 1048575
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_WIDTH-1:0] job_start_addr,
    input  logic [ADDR_WIDTH-1:0] job_end_addr,
    input  logic                  bias_valid,
    output logic                  bias_ready,
    input  logic [DATA_WIDTH-1:0] bias_data,
    output logic                  lstm_start,
    output logic [ADDR_WIDTH-1:0] lstm_start_addr,
    output logic [ADDR_WIDTH-1:0] lstm_end_addr,
    output logic                  lstm_wren_a,
    output logic [DATA_WIDTH-1:0] lstm_wdata_b,
    output logic                  lstm_reset,
    input  logic                  ht_valid,
    input  logic                  cycle_complete,
    input  logic                  lstm_done,
    output logic                  busy,
    output logic                  job_done,
    output logic                  err_range,
    output logic                  err_count,
    output logic                  err_timeout,
    output logic [15:0]           ht_total
);

    localparam int BCW = (NUM_BIAS > 1) ? $clog2(NUM_BIAS) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int EW  = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_REPORT, S_CLEAR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
    logic [BCW-1:0]        bias_cnt_q, bias_cnt_d;
    logic [15:0]           beat_cnt_q, beat_cnt_d;
    logic [15:0]           cyc_cnt_q, cyc_cnt_d;
    logic [15:0]           ht_total_q, ht_total_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                  clr_cnt_q, clr_cnt_d;
    logic                  err_range_q, err_range_d;
    logic                  err_count_q, err_count_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  done_prev_q, done_prev_d;
    logic                  wren_q, wren_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  lstm_start_q, lstm_start_d;
    logic                  job_done_q, job_done_d;
    logic                  lstm_reset_q, lstm_reset_d;
    logic                  busy_q, busy_d;

    // Counts including this cycle's beat / pulse; all saturate at 16 bits.
    logic [15:0]   beat_eff, cyc_eff;
    logic [EW-1:0] exp_cyc;
    logic          done_rise;

    assign beat_eff  = (ht_valid && beat_cnt_q != 16'hFFFF) ? beat_cnt_q + 16'd1 : beat_cnt_q;
    assign cyc_eff   = (cycle_complete && cyc_cnt_q != 16'hFFFF) ? cyc_cnt_q + 16'd1 : cyc_cnt_q;
    // One extra bit so a full 0..127 range yields 128 instead of wrapping.
    assign exp_cyc   = {1'b0, end_addr_q} - {1'b0, start_addr_q} + EW'(1);
    assign done_rise = lstm_done && !done_prev_q;

    // A Done still held from the previous job keeps new jobs out.
    assign job_ready  = (state_q == S_IDLE) && !lstm_done;
    assign bias_ready = (state_q == S_LOAD);

    always_comb begin
        state_d       = state_q;
        start_addr_d  = start_addr_q;
        end_addr_d    = end_addr_q;
        bias_cnt_d    = bias_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        cyc_cnt_d     = cyc_cnt_q;
        ht_total_d    = ht_total_q;
        tmo_cnt_d     = tmo_cnt_q;
        clr_cnt_d     = clr_cnt_q;
        err_range_d   = err_range_q;
        err_count_d   = err_count_q;
        err_timeout_d = err_timeout_q;
        done_prev_d   = lstm_done;
        wren_d        = 1'b0;
        wdata_d       = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    start_addr_d  = job_start_addr;
                    end_addr_d    = job_end_addr;
                    bias_cnt_d    = '0;
                    beat_cnt_d    = '0;
                    cyc_cnt_d     = '0;
                    ht_total_d    = '0;
                    err_count_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    err_range_d   = (job_end_addr < job_start_addr);
                    state_d       = (job_end_addr < job_start_addr) ? S_REPORT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bias_valid) begin
                    wren_d  = 1'b1;
                    wdata_d = bias_data;
                    if (bias_cnt_q == BCW'(NUM_BIAS - 1)) begin
                        state_d = S_START;
                    end else begin
                        bias_cnt_d = bias_cnt_q + BCW'(1);
                    end
                end
            end
            S_START: begin
                tmo_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (ht_valid && ht_total_q != 16'hFFFF) begin
                    ht_total_d = ht_total_q + 16'd1;
                end
                beat_cnt_d = beat_eff;
                if (cycle_complete) begin
                    if (beat_eff != 16'(HT_PER_CYCLE)) begin
                        err_count_d = 1'b1;
                    end
                    beat_cnt_d = '0;
                    cyc_cnt_d  = cyc_eff;
                end
                // Done wins over a timeout landing on the same cycle.
                if (done_rise) begin
                    if (cyc_eff != 16'(exp_cyc) || beat_cnt_d != 16'd0) begin
                        err_count_d = 1'b1;
                    end
                    state_d = S_REPORT;
                end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_REPORT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_REPORT: begin
                // A range error never touched the LSTM, so nothing to clear.
                clr_cnt_d = 1'b0;
                state_d   = err_range_q ? S_IDLE : S_CLEAR;
            end
            S_CLEAR: begin
                if (clr_cnt_q) begin
                    state_d = S_IDLE;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        lstm_start_d = (state_d == S_START);
        job_done_d   = (state_d == S_REPORT);
        lstm_reset_d = (state_d == S_CLEAR);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_addr_q  <= '0;
            end_addr_q    <= '0;
            bias_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            cyc_cnt_q     <= '0;
            ht_total_q    <= '0;
            tmo_cnt_q     <= '0;
            clr_cnt_q     <= 1'b0;
            err_range_q   <= 1'b0;
            err_count_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            done_prev_q   <= 1'b0;
            wren_q        <= 1'b0;
            wdata_q       <= '0;
            lstm_start_q  <= 1'b0;
            job_done_q    <= 1'b0;
            lstm_reset_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_addr_q  <= start_addr_d;
            end_addr_q    <= end_addr_d;
            bias_cnt_q    <= bias_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            ht_total_q    <= ht_total_d;
            tmo_cnt_q     <= tmo_cnt_d;
            clr_cnt_q     <= clr_cnt_d;
            err_range_q   <= err_range_d;
            err_count_q   <= err_count_d;
            err_timeout_q <= err_timeout_d;
            done_prev_q   <= done_prev_d;
            wren_q        <= wren_d;
            wdata_q       <= wdata_d;
            lstm_start_q  <= lstm_start_d;
            job_done_q    <= job_done_d;
            lstm_reset_q  <= lstm_reset_d;
            busy_q        <= busy_d;
        end
    end

    assign lstm_start      = lstm_start_q;
    assign lstm_start_addr = start_addr_q;
    assign lstm_end_addr   = end_addr_q;
    assign lstm_wren_a     = wren_q;
    assign lstm_wdata_b    = wdata_q;
    assign lstm_reset      = lstm_reset_q;
    assign busy            = busy_q;
    assign job_done        = job_done_q;
    assign err_range       = err_range_q;
    assign err_count       = err_count_q;
    assign err_timeout     = err_timeout_q;
    assign ht_total        = ht_total_q;

endmodule

// File: tb/tb_lstm_job_ctrl.sv
// Testbench for lstm_job_ctrl: a driver plays job source, bias source and
// LSTM; expected job results and bias writes go into queues that a negedge
// monitor pops whenever the DUT presents job_done or lstm_wren_a.
module tb_lstm_job_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 7;
    localparam int NB  = 256;
    localparam int HPC = 64;
    localparam int TMO = 300;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          job_valid = 1'b0, job_ready;
    logic [AW-1:0] job_start_addr = '0, job_end_addr = '0;
    logic          bias_valid = 1'b0, bias_ready;
    logic [DW-1:0] bias_data = '0;
    logic          lstm_start;
    logic [AW-1:0] lstm_start_addr, lstm_end_addr;
    logic          lstm_wren_a;
    logic [DW-1:0] lstm_wdata_b;
    logic          lstm_reset;
    logic          ht_valid = 1'b0, cycle_complete = 1'b0, lstm_done = 1'b0;
    logic          busy, job_done, err_range, err_count, err_timeout;
    logic [15:0]   ht_total;

    lstm_job_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BIAS(NB),
        .HT_PER_CYCLE(HPC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_start_addr(job_start_addr), .job_end_addr(job_end_addr),
        .bias_valid(bias_valid), .bias_ready(bias_ready), .bias_data(bias_data),
        .lstm_start(lstm_start), .lstm_start_addr(lstm_start_addr),
        .lstm_end_addr(lstm_end_addr),
        .lstm_wren_a(lstm_wren_a), .lstm_wdata_b(lstm_wdata_b),
        .lstm_reset(lstm_reset),
        .ht_valid(ht_valid), .cycle_complete(cycle_complete), .lstm_done(lstm_done),
        .busy(busy), .job_done(job_done),
        .err_range(err_range), .err_count(err_count), .err_timeout(err_timeout),
        .ht_total(ht_total)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit rng; bit cnt; bit tmo;
        int ht; int lo; int hi; int wr; int st;
    } exp_t;
    typedef struct { int data; int cyc; } bq_t;

    exp_t sb[$];
    bq_t  bq[$];
    int   checks = 0, errors = 0;
    int   wr_cnt = 0, st_cnt = 0, rst_cnt = 0, start_cyc = -1;
    int   exp_sa = 0, exp_ea = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name, input string act, input string req);
        checks++;
        errors++;
        $display("FAIL %s: actual=%s required=%s (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops expectations when the DUT presents a write or a result.
    always @(negedge clk) begin
        if (reset) begin
            wr_cnt  = 0;
            st_cnt  = 0;
            rst_cnt = 0;
        end else begin
            if (lstm_wren_a) begin
                if (bq.size() == 0) begin
                    fail("unexpected_wren", "write", "none");
                end else begin
                    bq_t b;
                    b = bq.pop_front();
                    chk("wdata", 64'(lstm_wdata_b), 64'(b.data));
                    chk("wren_cycle", 64'(cyc), 64'(b.cyc));
                end
                wr_cnt++;
            end
            if (lstm_start) begin
                st_cnt++;
                start_cyc = cyc;
                chk("lstm_start_addr", 64'(lstm_start_addr), 64'(exp_sa));
                chk("lstm_end_addr", 64'(lstm_end_addr), 64'(exp_ea));
            end
            if (lstm_reset) rst_cnt++;
            if (job_done) begin
                if (sb.size() == 0) begin
                    fail("unexpected_job_done", "job_done", "none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err_range", 64'(err_range), 64'(e.rng));
                    chk("err_count", 64'(err_count), 64'(e.cnt));
                    chk("err_timeout", 64'(err_timeout), 64'(e.tmo));
                    chk("ht_total", 64'(ht_total), 64'(e.ht));
                    chk("bias_writes", 64'(wr_cnt), 64'(e.wr));
                    chk("start_pulses", 64'(st_cnt), 64'(e.st));
                    if (cyc < e.lo || cyc > e.hi) begin
                        checks++;
                        errors++;
                        $display("FAIL job_done_cycle: actual=%0d required=%0d..%0d", cyc, e.lo, e.hi);
                    end else begin
                        checks++;
                    end
                end
                wr_cnt  = 0;
                st_cnt  = 0;
                rst_cnt = 0;
            end
        end
    end

    task automatic load_bias(input int gap, output int last_cyc);
        last_cyc = -1;
        for (int n = 0; n < NB; n++) begin
            repeat (gap) begin
                bias_valid = 1'b0;
                @(negedge clk);
            end
            if (!bias_ready) begin
                fail("bias_ready", "0", "1");
                bias_valid = 1'b0;
                return;
            end
            bias_valid = 1'b1;
            bias_data  = 16'($urandom);
            bq.push_back('{int'(bias_data), cyc + 1});
            last_cyc = cyc;
            @(negedge clk);
        end
        bias_valid = 1'b0;
    endtask

    // One job end to end. Expected results come from the stimulus plan:
    // each cycle must carry HPC beats, the cycle count must equal
    // end-start+1, and a missing Done means a timeout.
    task automatic run_job(input int sa, input int ea, input int gap, input int ncyc,
                           input int short_idx, input bit send_done, input int abort_at);
        exp_t e;
        int   acc, last_b, n, sent, nb;
        bit   rng;
        rng = (ea < sa);
        n = 0;
        while (!job_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!job_ready) fail("job_ready_wait", "0", "1");
        job_valid      = 1'b1;
        job_start_addr = AW'(sa);
        job_end_addr   = AW'(ea);
        exp_sa = sa;
        exp_ea = ea;
        acc    = cyc;
        if (rng) begin
            e.rng = 1'b1; e.cnt = 1'b0; e.tmo = 1'b0; e.ht = 0;
            e.lo = acc + 1; e.hi = acc + 1; e.wr = 0; e.st = 0;
            sb.push_back(e);
        end
        @(negedge clk);
        job_valid = 1'b0;
        if (!rng) begin
            load_bias(gap, last_b);
            n = 0;
            while (start_cyc <= acc && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (start_cyc <= acc) begin
                fail("lstm_start_wait", "none", "pulse");
                return;
            end
            chk("start_after_last_bias", 64'(start_cyc), 64'(last_b + 1));
            @(negedge clk);
            sent = 0;
            for (int c = 0; c < ncyc; c++) begin
                nb = (c == short_idx) ? HPC - 1 : HPC;
                for (int b = 0; b < nb; b++) begin
                    if (abort_at >= 0 && sent == abort_at) begin
                        reset = 1'b1;
                        ht_valid = 1'b0;
                        cycle_complete = 1'b0;
                        repeat (2) @(negedge clk);
                        chk("abort_busy", 64'(busy), 64'd0);
                        chk("abort_ht_total", 64'(ht_total), 64'd0);
                        chk("abort_err_count", 64'(err_count), 64'd0);
                        reset = 1'b0;
                        @(negedge clk);
                        return;
                    end
                    ht_valid       = 1'b1;
                    cycle_complete = (b == nb - 1);
                    sent++;
                    @(negedge clk);
                end
            end
            ht_valid       = 1'b0;
            cycle_complete = 1'b0;
            e.rng = 1'b0;
            e.cnt = (short_idx >= 0) || (send_done && ncyc != ea - sa + 1);
            e.tmo = !send_done;
            e.ht  = sent;
            e.wr  = NB;
            e.st  = 1;
            if (send_done) begin
                lstm_done = 1'b1;
                e.lo = cyc + 1;
                e.hi = cyc + 1;
                sb.push_back(e);
                n = 0;
                while (!lstm_reset && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (!lstm_reset) fail("lstm_reset_wait", "0", "1");
                lstm_done = 1'b0;
            end else begin
                // Timeout may land TMO or TMO+1 cycles after RUN entry.
                e.lo = start_cyc + 1 + TMO;
                e.hi = start_cyc + 2 + TMO;
                sb.push_back(e);
            end
        end
        n = 0;
        while ((busy || sb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb.size() != 0) fail("job_finish_wait", "busy", "idle");
        chk("lstm_reset_cycles", 64'(rst_cnt), rng ? 64'd0 : 64'd2);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        chk("rst_lstm_start", 64'(lstm_start), 64'd0);
        chk("rst_lstm_reset", 64'(lstm_reset), 64'd0);
        chk("rst_wren", 64'(lstm_wren_a), 64'd0);
        chk("rst_ht_total", 64'(ht_total), 64'd0);
        chk("rst_err_range", 64'(err_range), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_err_timeout", 64'(err_timeout), 64'd0);
        chk("rst_job_ready", 64'(job_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // A lingering Done in IDLE holds off new jobs.
        lstm_done = 1'b1;
        @(negedge clk);
        chk("ready_blocked_by_done", 64'(job_ready), 64'd0);
        lstm_done = 1'b0;
        @(negedge clk);
        chk("ready_after_done_low", 64'(job_ready), 64'd1);

        run_job(0, 3, 0, 4, -1, 1'b1, -1);     // clean 4-cycle job
        run_job(10, 5, 0, 0, -1, 1'b1, -1);    // range error
        run_job(0, 3, 0, 4, 2, 1'b1, -1);      // one 63-beat cycle
        run_job(20, 21, 2, 2, -1, 1'b1, -1);   // bias every 3rd cycle
        run_job(5, 6, 0, 0, -1, 1'b0, -1);     // no Done: timeout
        run_job(0, 1, 0, 2, -1, 1'b1, 30);     // reset mid-RUN
        run_job(0, 0, 1, 1, -1, 1'b1, -1);     // clean job after abort
        run_job(0, 127, 0, 1, -1, 1'b1, -1);   // full range, wrong count

        for (int i = 0; i < 6; i++) begin
            int kind, gap, len, sa, idx;
            kind = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 2));
            len  = int'($urandom_range(1, 4));
            sa   = int'($urandom_range(1, 123));
            case (kind)
                0: run_job(sa, sa + len - 1, gap, len, -1, 1'b1, -1);
                1: begin
                    idx = int'($urandom_range(0, len - 1));
                    run_job(sa, sa + len - 1, gap, len, idx, 1'b1, -1);
                end
                2: run_job(sa, sa + len - 1, gap, (len > 1) ? len - 1 : 2, -1, 1'b1, -1);
                default: run_job(sa, int'($urandom_range(0, sa - 1)), gap, 0, -1, 1'b1, -1);
            endcase
        end

        repeat (5) @(negedge clk);
        if (sb.size() != 0) fail("pending_results", "left", "empty");
        if (bq.size() != 0) fail("pending_writes", "left", "empty");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
